lfsr_ctrl: RTL and testbench

Sequencer for one LFSR instance. It accepts a configuration (tap, seed, word count) over a val/rdy handshake, seeds the LFSR, and steps it one bit per cycle. The serial output is packed into nbits-wide words and delivered on a val/rdy output stream. It stalls the LFSR under backpressure and sits between the host and the LFSR datapath.

---
 rtl/lfsr_ctrl.sv | 139 +++++++++++++
 tb/tb_lfsr_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: sequencer for one external LFSR instance.
//
// Takes a configuration (tap mask, seed, word count) over a val/rdy
// handshake, seeds the LFSR for one cycle, then steps it one bit per cycle.
// The serial bits are packed MSB-first into nbits-wide words and presented
// on a val/rdy output stream. While a word waits for the consumer, the LFSR
// is frozen, so no bits are lost under backpressure.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   cfg_val/cfg_rdy         configuration handshake (accepted only when idle)
//   cfg_tap, cfg_seed       LFSR tap mask and initial state
//   cfg_count               words to produce; 0 runs until stop
//   stop                    finish after the word currently in progress
//   out_val/out_rdy/out_msg packed output word stream
//   busy                    controller is not idle
//   done                    one-cycle pulse after the final word is taken
//   lfsr_reset/enable       seed-load and step controls to the LFSR
//   lfsr_tap, lfsr_seed     registered configuration to the LFSR
//   lfsr_out                LFSR serial bit (current state)
module lfsr_ctrl #(
    parameter int nbits = 8,
    parameter int cw    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_val,
    output logic             cfg_rdy,
    input  logic [nbits-1:0] cfg_tap,
    input  logic [nbits-1:0] cfg_seed,
    input  logic [cw-1:0]    cfg_count,
    input  logic             stop,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out_msg,
    output logic             busy,
    output logic             done,
    output logic             lfsr_reset,
    output logic             lfsr_enable,
    output logic [nbits-1:0] lfsr_tap,
    output logic [nbits-1:0] lfsr_seed,
    input  logic             lfsr_out
);

    localparam int bw = $clog2(nbits + 1);

    typedef enum logic [1:0] {IDLE, SEED, RUN, HOLD} state_t;

    state_t           state;
    logic [cw-1:0]    words_left;
    logic             cont;        // continuous mode: words_left is frozen
    logic             stop_pend;
    logic             seed_q;      // registered "state == SEED"
    logic [bw-1:0]    bitcnt;
    logic [nbits-1:0] sreg;
    logic             last_word;

    // A stop arriving in the handshake cycle itself also ends the run there.
    assign last_word = stop_pend | stop | (!cont && words_left == cw'(1));

    // The LFSR must be held in reset while the controller is.
    assign lfsr_reset = reset | seed_q;
    assign out_msg    = sreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cfg_rdy     <= 1'b1;
            busy        <= 1'b0;
            out_val     <= 1'b0;
            lfsr_enable <= 1'b0;
            done        <= 1'b0;
            seed_q      <= 1'b0;
            lfsr_tap    <= '0;
            lfsr_seed   <= '0;
            words_left  <= '0;
            cont        <= 1'b0;
            stop_pend   <= 1'b0;
            bitcnt      <= '0;
            sreg        <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && stop)
                stop_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (cfg_val) begin
                        lfsr_tap   <= cfg_tap;
                        lfsr_seed  <= cfg_seed;
                        words_left <= cfg_count;
                        cont       <= (cfg_count == '0);
                        stop_pend  <= 1'b0;
                        cfg_rdy    <= 1'b0;
                        busy       <= 1'b1;
                        seed_q     <= 1'b1;
                        state      <= SEED;
                    end
                end
                SEED: begin
                    seed_q      <= 1'b0;
                    bitcnt      <= '0;
                    sreg        <= '0;
                    lfsr_enable <= 1'b1;
                    state       <= RUN;
                end
                RUN: begin
                    // First bit of the word ends up in the MSB.
                    sreg   <= {sreg[nbits-2:0], lfsr_out};
                    bitcnt <= bitcnt + bw'(1);
                    if (bitcnt == bw'(nbits - 1)) begin
                        lfsr_enable <= 1'b0;
                        out_val     <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_rdy) begin
                        out_val <= 1'b0;
                        if (!cont)
                            words_left <= words_left - cw'(1);
                        if (last_word) begin
                            cfg_rdy <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bitcnt      <= '0;
                            lfsr_enable <= 1'b1;
                            state       <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Testbench for lfsr_ctrl. The LFSR is stood in for by a random bit stream
// that restarts on lfsr_reset and advances on each enabled edge; expected
// words are packed from that stream and queued for a decoupled monitor.
module tb_lfsr_ctrl;
    localparam int NB = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_val = 1'b0;
    logic          cfg_rdy;
    logic [NB-1:0] cfg_tap = '0;
    logic [NB-1:0] cfg_seed = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          stop = 1'b0;
    logic          out_val;
    logic          out_rdy = 1'b0;
    logic [NB-1:0] out_msg;
    logic          busy, done, lfsr_reset, lfsr_enable;
    logic [NB-1:0] lfsr_tap, lfsr_seed;
    logic          lfsr_out;

    lfsr_ctrl #(.nbits(NB), .cw(CW)) dut (
        .clk(clk), .reset(reset),
        .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
        .cfg_tap(cfg_tap), .cfg_seed(cfg_seed), .cfg_count(cfg_count),
        .stop(stop),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
        .busy(busy), .done(done),
        .lfsr_reset(lfsr_reset), .lfsr_enable(lfsr_enable),
        .lfsr_tap(lfsr_tap), .lfsr_seed(lfsr_seed), .lfsr_out(lfsr_out)
    );

    always #5 clk = ~clk;

    logic       bits [512];
    logic [8:0] idx = '0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [NB-1:0] expq [$];
    int         hs_cnt = 0;
    int         hs_t [$];

    assign lfsr_out = bits[idx];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lfsr_reset)       idx <= '0;
        else if (lfsr_enable) idx <= idx + 9'd1;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, a, e);
        end
    endtask

    // Scoreboard monitor: one pop per accepted word.
    always @(negedge clk) begin
        if (!reset && out_val && out_rdy) begin
            hs_cnt++;
            hs_t.push_back(cyc);
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word got=%0h want=none", out_msg);
            end else begin
                chk("word", {24'd0, out_msg}, {24'd0, expq.pop_front()});
            end
        end
    end

    // Word k of a run is bits 8k..8k+7 of the stream, first bit weighted 128.
    function automatic logic [NB-1:0] word_of(input int k);
        int w = 0;
        for (int j = 0; j < NB; j++)
            w = w + (int'(bits[NB*k + j]) << (NB - 1 - j));
        return NB'(w);
    endfunction

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) expq.push_back(word_of(k));
    endtask

    task automatic rand_bits();
        for (int i = 0; i < 512; i++) bits[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step into the SEED cycle.
    task automatic send_cfg(input logic [NB-1:0] t, input logic [NB-1:0] s,
                            input logic [CW-1:0] c);
        chk("cfg_rdy_idle", {31'd0, cfg_rdy}, 32'd1);
        cfg_tap = t; cfg_seed = s; cfg_count = c; cfg_val = 1'b1;
        tick();
        cfg_val = 1'b0;
    endtask

    task automatic wait_val(input string n, input int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (out_val) begin ok = 1; break; end
        end
        if (!ok) chk(n, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string n, input int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        if (!ok) chk(n, 32'd0, 32'd1);
    endtask

    initial begin
        int base, tb0, en, dn;
        logic [NB-1:0] s1;

        // reset state
        for (int i = 0; i < 512; i++) bits[i] = 1'b0;
        @(negedge clk);
        chk("rst_cfg_rdy", {31'd0, cfg_rdy}, 1);
        chk("rst_out_val", {31'd0, out_val}, 0);
        chk("rst_out_msg", {24'd0, out_msg}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_enable", {31'd0, lfsr_enable}, 0);
        chk("rst_tap", {24'd0, lfsr_tap}, 0);
        chk("rst_seed", {24'd0, lfsr_seed}, 0);
        chk("rst_lfsr_reset", {31'd0, lfsr_reset}, 1);
        tick();
        reset = 1'b0;
        tick();
        chk("idle_lfsr_reset", {31'd0, lfsr_reset}, 0);

        // single directed word: 1,0,1,1,0,0,1,0 -> B2
        bits[0] = 1; bits[1] = 0; bits[2] = 1; bits[3] = 1;
        bits[4] = 0; bits[5] = 0; bits[6] = 1; bits[7] = 0;
        expq.push_back(8'hB2);
        out_rdy = 1'b1;
        send_cfg(8'hB8, 8'h01, 16'd1);
        @(negedge clk);
        chk("seed_lfsr_reset", {31'd0, lfsr_reset}, 1);
        chk("seed_lfsr_seed", {24'd0, lfsr_seed}, 32'h01);
        chk("seed_lfsr_tap", {24'd0, lfsr_tap}, 32'hB8);
        chk("seed_busy", {31'd0, busy}, 1);
        chk("seed_cfg_rdy", {31'd0, cfg_rdy}, 0);
        en = 0;
        repeat (NB) begin
            @(negedge clk);
            en += int'(lfsr_enable);
        end
        chk("run_cycles", en, NB);
        @(negedge clk);
        chk("t10_out_val", {31'd0, out_val}, 1);
        chk("t10_out_msg", {24'd0, out_msg}, 32'hB2);
        @(negedge clk);
        chk("t11_done", {31'd0, done}, 1);
        chk("t11_cfg_rdy", {31'd0, cfg_rdy}, 1);
        chk("t11_busy", {31'd0, busy}, 0);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 0);

        // backpressure, count = 2
        tick();
        rand_bits();
        push_words(2);
        out_rdy = 1'b0;
        base = hs_cnt;
        send_cfg(8'($urandom), 8'($urandom), 16'd2);
        wait_val("bp_first_val", 20);
        for (int i = 0; i < 5; i++) begin
            chk("bp_enable", {31'd0, lfsr_enable}, 0);
            chk("bp_out_val", {31'd0, out_val}, 1);
            chk("bp_msg_stable", {24'd0, out_msg}, {24'd0, word_of(0)});
            if (i < 4) @(negedge clk);
        end
        tick();
        out_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_resume", {31'd0, lfsr_enable}, 1);
        chk("bp_no_early_done", {31'd0, done}, 0);
        wait_done("bp_done", 20);
        chk("bp_words", hs_cnt - base, 2);

        // continuous mode, stop mid-RUN of word 4
        tick();
        rand_bits();
        push_words(4);
        base = hs_cnt;
        tb0 = hs_t.size();
        send_cfg(8'($urandom), 8'($urandom), 16'd0);
        for (int i = 0; i < 60 && hs_cnt < base + 3; i++) @(negedge clk);
        chk("cont_three_words", hs_cnt - base, 3);
        tick(); tick(); tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("cont_done", 30);
        chk("cont_words", hs_cnt - base, 4);
        if (hs_t.size() >= tb0 + 4)
            for (int i = 1; i < 4; i++)
                chk("cont_period", hs_t[tb0 + i] - hs_t[tb0 + i - 1], NB + 1);
        repeat (12) @(negedge clk);
        chk("cont_no_extra", hs_cnt - base, 4);
        chk("cont_idle", {31'd0, busy}, 0);

        // stop coincident with the HOLD handshake
        tick();
        rand_bits();
        push_words(1);
        base = hs_cnt;
        send_cfg(8'($urandom), 8'($urandom), 16'd0);
        wait_val("stophs_val", 20);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        chk("stophs_done", {31'd0, done}, 1);
        chk("stophs_no_run", {31'd0, lfsr_enable}, 0);
        chk("stophs_busy", {31'd0, busy}, 0);
        chk("stophs_words", hs_cnt - base, 1);

        // config ignored while busy
        tick();
        rand_bits();
        push_words(1);
        s1 = 8'($urandom);
        send_cfg(8'($urandom), s1, 16'd1);
        tick(); tick();
        cfg_seed = ~s1;
        cfg_val = 1'b1;
        @(negedge clk);
        chk("busy_cfg_rdy", {31'd0, cfg_rdy}, 0);
        chk("busy_seed", {24'd0, lfsr_seed}, {24'd0, s1});
        tick();
        @(negedge clk);
        chk("busy_seed2", {24'd0, lfsr_seed}, {24'd0, s1});
        cfg_val = 1'b0;
        wait_done("busy_done", 20);
        chk("busy_seed_end", {24'd0, lfsr_seed}, {24'd0, s1});

        // reset asserted mid-RUN
        tick();
        rand_bits();
        out_rdy = 1'b0;
        send_cfg(8'($urandom), 8'($urandom), 16'd0);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_out_val", {31'd0, out_val}, 0);
        chk("mid_rst_enable", {31'd0, lfsr_enable}, 0);
        chk("mid_rst_lfsr_reset", {31'd0, lfsr_reset}, 1);
        chk("mid_rst_seed", {24'd0, lfsr_seed}, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cfg_rdy", {31'd0, cfg_rdy}, 1);
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            dn += int'(done) + int'(out_val);
        end
        chk("post_rst_quiet", dn, 0);

        chk("scoreboard_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end
endmodule
